// File: rtl/glcd_pkg.sv
// Shared types and constants for the graphic LCD refresh engine.
package glcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISP_ON  = 3'd1,
        ST_SET_PAGE = 3'd2,
        ST_SET_COL  = 3'd3,
        ST_FETCH    = 3'd4,
        ST_WRITE    = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam logic [7:0] CMD_DISP_ON  = 8'h3F;
    localparam logic [7:0] CMD_SET_PAGE = 8'hB8;
    localparam logic [7:0] CMD_SET_COL  = 8'h40;

    function automatic int glcd_aw(input int num_chips, input int cols, input int pages);
        return $clog2(num_chips * cols * pages);
    endfunction

    // Counter width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glcd_bus_strobe.sv
// Enable-strobe generator: one launch produces en_o low for EN_DIV cycles,
// then high for EN_DIV cycles, with txn_done on the final cycle.
module glcd_bus_strobe
    import glcd_pkg::*;
#(
    parameter int EN_DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic launch,
    output logic en_o,
    output logic txn_done
);

    localparam int            CW       = $clog2(2 * EN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * EN_DIV - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(EN_DIV);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;

    assign txn_done = active_q && (cnt_q == CNT_LAST);
    assign en_o     = en_q;

    // A launch on the done cycle restarts the phase counter, so transactions abut.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (launch) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (txn_done) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
        end
        en_d = active_d && (cnt_d >= CNT_HIGH);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
        end
    end

endmodule

// File: rtl/glcd_refresh_engine.sv
// Streams a full frame from a framebuffer read port onto a KS0108-style LCD bus,
// page by page across NUM_CHIPS column drivers, with an optional clear mode.
module glcd_refresh_engine
    import glcd_pkg::*;
#(
    parameter int NUM_CHIPS  = 2,
    parameter int COLS       = 64,
    parameter int PAGES      = 8,
    parameter int EN_DIV     = 1,
    parameter int RST_CYCLES = 4,
    parameter int AW         = glcd_aw(NUM_CHIPS, COLS, PAGES)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic                 mode_i,
    output logic                 fb_rd_o,
    output logic [AW-1:0]        fb_addr_o,
    input  logic [7:0]           fb_data_i,
    input  logic                 fb_valid_i,
    output logic [7:0]           db_o,
    output logic                 dori_o,
    output logic                 rw_o,
    output logic                 en_o,
    output logic                 rst_o,
    output logic [NUM_CHIPS-1:0] cs_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2:0]           state_o
);

    localparam int CHW = idx_w(NUM_CHIPS);
    localparam int COW = idx_w(COLS);
    localparam int PGW = idx_w(PAGES);
    localparam int RCW = idx_w(RST_CYCLES);

    localparam logic [CHW-1:0] CHIP_LAST = CHW'(NUM_CHIPS - 1);
    localparam logic [COW-1:0] COL_LAST  = COW'(COLS - 1);
    localparam logic [PGW-1:0] PAGE_LAST = PGW'(PAGES - 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [1:0]             hist_q, hist_d;
    logic                   mode_q, mode_d;
    logic                   rst_q, rst_d;
    logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [COW-1:0]         col_q, col_d;
    logic [CHW-1:0]         chip_q, chip_d;
    logic [PGW-1:0]         page_q, page_d;
    logic [7:0]             db_q, db_d;
    logic                   dori_q, dori_d;
    logic [NUM_CHIPS-1:0]   cs_q, cs_d;

    logic launch;
    logic txn_done;
    logic start_acc;
    logic next_data;

    function automatic logic [NUM_CHIPS-1:0] chip_sel(input logic [CHW-1:0] c);
        logic [NUM_CHIPS-1:0] sel;
        sel    = '0;
        sel[c] = 1'b1;
        return sel;
    endfunction

    glcd_bus_strobe #(
        .EN_DIV (EN_DIV)
    ) u_strobe (
        .clk      (clk),
        .rstn     (rstn),
        .launch   (launch),
        .en_o     (en_o),
        .txn_done (txn_done)
    );

    // hist_q[1] is the newest start_i sample, hist_q[0] the one before it.
    assign hist_d = {start_i, hist_q[1]};

    always_comb begin
        rst_d     = rst_q;
        rst_cnt_d = rst_cnt_q;
        if (rst_q) begin
            if (rst_cnt_q == RST_LAST) rst_d = 1'b0;
            else                       rst_cnt_d = rst_cnt_q + RCW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        col_d     = col_q;
        chip_d    = chip_q;
        page_d    = page_q;
        db_d      = db_q;
        dori_d    = dori_q;
        cs_d      = cs_q;
        launch    = 1'b0;
        next_data = 1'b0;
        start_acc = (state_q == ST_IDLE) && !rst_q && (hist_q == 2'b10);

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    mode_d  = mode_i;
                    col_d   = '0;
                    chip_d  = '0;
                    page_d  = '0;
                    state_d = ST_DISP_ON;
                    launch  = 1'b1;
                    db_d    = CMD_DISP_ON;
                    dori_d  = 1'b0;
                    cs_d    = '1;
                end
            end
            ST_DISP_ON: begin
                if (txn_done) begin
                    state_d = ST_SET_PAGE;
                    launch  = 1'b1;
                    db_d    = CMD_SET_PAGE | 8'(page_q);
                    dori_d  = 1'b0;
                    cs_d    = '1;
                end
            end
            ST_SET_PAGE: begin
                if (txn_done) begin
                    state_d = ST_SET_COL;
                    launch  = 1'b1;
                    db_d    = CMD_SET_COL;
                    dori_d  = 1'b0;
                    cs_d    = '1;
                end
            end
            ST_SET_COL: begin
                if (txn_done) next_data = 1'b1;
            end
            ST_FETCH: begin
                if (fb_valid_i) begin
                    state_d = ST_WRITE;
                    launch  = 1'b1;
                    db_d    = fb_data_i;
                    dori_d  = 1'b1;
                    cs_d    = chip_sel(chip_q);
                end
            end
            ST_WRITE: begin
                // Column auto-increments in the LCD; only page changes need an instruction.
                if (txn_done) begin
                    if (col_q != COL_LAST) begin
                        col_d     = col_q + COW'(1);
                        next_data = 1'b1;
                    end else begin
                        col_d = '0;
                        if (chip_q != CHIP_LAST) begin
                            chip_d    = chip_q + CHW'(1);
                            next_data = 1'b1;
                        end else begin
                            chip_d = '0;
                            if (page_q != PAGE_LAST) begin
                                page_d  = page_q + PGW'(1);
                                state_d = ST_SET_PAGE;
                                launch  = 1'b1;
                                db_d    = CMD_SET_PAGE | 8'(page_d);
                                dori_d  = 1'b0;
                                cs_d    = '1;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (next_data) begin
            if (mode_q) begin
                state_d = ST_WRITE;
                launch  = 1'b1;
                db_d    = 8'h00;
                dori_d  = 1'b1;
                cs_d    = chip_sel(chip_d);
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            hist_q    <= '0;
            mode_q    <= 1'b0;
            rst_q     <= 1'b1;
            rst_cnt_q <= '0;
            col_q     <= '0;
            chip_q    <= '0;
            page_q    <= '0;
            db_q      <= '0;
            dori_q    <= 1'b0;
            cs_q      <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            mode_q    <= mode_d;
            rst_q     <= rst_d;
            rst_cnt_q <= rst_cnt_d;
            col_q     <= col_d;
            chip_q    <= chip_d;
            page_q    <= page_d;
            db_q      <= db_d;
            dori_q    <= dori_d;
            cs_q      <= cs_d;
        end
    end

    assign fb_rd_o   = (state_q == ST_FETCH);
    assign fb_addr_o = AW'((int'(page_q) * NUM_CHIPS + int'(chip_q)) * COLS + int'(col_q));
    assign db_o      = db_q;
    assign dori_o    = dori_q;
    assign rw_o      = 1'b0;
    assign rst_o     = rst_q;
    assign cs_o      = cs_q;
    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o    = (state_q == ST_DONE);
    assign state_o   = state_q;

endmodule
